// File: rtl/fifo_rd_arb_ctrl_if.sv
// rtl/fifo_rd_arb_ctrl_if.sv - request/empty/data bundle between FIFOs, consumer and read arbiter
interface fifo_rd_arb_ctrl_if #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 8
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH-1:0]        i_ren;
  logic [NUM_CH-1:0]        i_empty;
  logic                     i_stall;
  logic [NUM_CH*DATA_W-1:0] i_rdata;
  logic [NUM_CH-1:0]        o_ren_ctrl;
  logic [DATA_W-1:0]        o_rdata;
  logic                     o_rvalid;
  logic [CH_W-1:0]          o_rch;
  logic                     o_busy;
  logic                     o_burst_done;

  modport slave (
    input  i_ren, i_empty, i_stall, i_rdata,
    output o_ren_ctrl, o_rdata, o_rvalid, o_rch, o_busy, o_burst_done
  );

  modport master (
    output i_ren, i_empty, i_stall, i_rdata,
    input  o_ren_ctrl, o_rdata, o_rvalid, o_rch, o_busy, o_burst_done
  );
endinterface

// File: rtl/fifo_rd_arb_ctrl.sv
// rtl/fifo_rd_arb_ctrl.sv - round-robin burst read arbiter over NUM_CH FIFOs
// with a read-latency pipeline returning tagged, registered data.
module fifo_rd_arb_ctrl #(
  parameter int NUM_CH    = 4,
  parameter int DATA_W    = 8,
  parameter int BURST_LEN = 4,
  parameter int RD_LAT    = 1
) (
  input  logic               i_clk,
  input  logic               i_rest,
  fifo_rd_arb_ctrl_if.slave  bus
);
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CNT_W = $clog2(BURST_LEN) + 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);
  localparam logic [CH_W-1:0]  LAST_CH   = CH_W'(NUM_CH - 1);

  typedef enum logic {IDLE, BURST} state_t;

  state_t             state_q;
  logic [CH_W-1:0]    grant_q;
  logic [CH_W-1:0]    last_grant_q;
  logic [CNT_W-1:0]   beat_q;
  logic               burst_done_q;

  logic [RD_LAT-1:0]  pv_q;
  logic [CH_W-1:0]    pch_q [RD_LAT];
  logic [DATA_W-1:0]  rdata_q;
  logic               rvalid_q;
  logic [CH_W-1:0]    rch_q;

  logic [NUM_CH-1:0]  elig;
  logic               any_elig;
  logic [CH_W-1:0]    pick_d;
  int                 idx;

  // Walk downwards so the channel closest after last_grant is the last writer.
  always_comb begin
    elig     = bus.i_ren & ~bus.i_empty;
    any_elig = 1'b0;
    pick_d   = '0;
    idx      = 0;
    for (int i = NUM_CH; i >= 1; i--) begin
      idx = (int'(last_grant_q) + i) % NUM_CH;
      if (elig[CH_W'(idx)]) begin
        any_elig = 1'b1;
        pick_d   = CH_W'(idx);
      end
    end
  end

  logic g_ren;
  logic g_empty;
  logic issue;
  logic exit_burst;
  logic [NUM_CH-1:0] ren_ctrl;

  assign g_ren      = bus.i_ren[grant_q];
  assign g_empty    = bus.i_empty[grant_q];
  assign issue      = (state_q == BURST) && g_ren && !g_empty && !bus.i_stall;
  assign exit_burst = (state_q == BURST) &&
                      ((issue && (beat_q == LAST_BEAT)) || g_empty || !g_ren);

  always_comb begin
    ren_ctrl = '0;
    if (issue) ren_ctrl[grant_q] = 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_rest) begin
    if (!i_rest) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= LAST_CH;
      beat_q       <= '0;
      burst_done_q <= 1'b0;
    end else begin
      burst_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (any_elig) begin
            grant_q <= pick_d;
            beat_q  <= '0;
            state_q <= BURST;
          end
        end
        BURST: begin
          if (issue) beat_q <= beat_q + CNT_W'(1);
          if (exit_burst) begin
            state_q      <= IDLE;
            last_grant_q <= grant_q;
            burst_done_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Stage RD_LAT-1 lines up with the cycle the FIFO drives the data.
  always_ff @(posedge i_clk or negedge i_rest) begin
    if (!i_rest) begin
      pv_q <= '0;
      for (int s = 0; s < RD_LAT; s++) pch_q[s] <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      rch_q    <= '0;
    end else begin
      pv_q[0]  <= issue;
      pch_q[0] <= grant_q;
      for (int s = 1; s < RD_LAT; s++) begin
        pv_q[s]  <= pv_q[s-1];
        pch_q[s] <= pch_q[s-1];
      end
      rvalid_q <= pv_q[RD_LAT-1];
      if (pv_q[RD_LAT-1]) begin
        rdata_q <= bus.i_rdata[int'(pch_q[RD_LAT-1])*DATA_W +: DATA_W];
        rch_q   <= pch_q[RD_LAT-1];
      end
    end
  end

  assign bus.o_ren_ctrl   = ren_ctrl;
  assign bus.o_rdata      = rdata_q;
  assign bus.o_rvalid     = rvalid_q;
  assign bus.o_rch        = rch_q;
  assign bus.o_burst_done = burst_done_q;
  assign bus.o_busy       = (state_q != IDLE) || (|pv_q) || rvalid_q;

endmodule

// File: doc/fifo_rd_arb_ctrl.md
Name: fifo_rd_arb_ctrl

Overview:
Multi-channel successor to the single-channel FIFO read-enable controller. Arbitrates read requests from NUM_CH FIFOs round-robin and issues bursts of up to BURST_LEN reads to the granted FIFO. Never reads an empty FIFO and honours a downstream stall. Tracks FIFO read latency and returns tagged, registered read data to the consumer.

Parameters:
NUM_CH, 4, number of FIFO channels (2..16)
DATA_W, 8, FIFO data width per channel
BURST_LEN, 4, max reads per grant before re-arbitration (1..64)
RD_LAT, 1, FIFO read latency in cycles from ren to valid i_rdata (1..4)
CH_W, clog2(NUM_CH) (min 1), width of channel id; derived, not overridable

Ports:
i_clk  input  1  clock; all state on rising edge
i_rest  input  1  reset, asynchronous, active-low (0 = reset)
i_ren  input  NUM_CH  per-channel read request from consumer logic
i_empty  input  NUM_CH  per-channel FIFO empty flag
i_stall  input  1  downstream stall; 1 = issue no new reads
i_rdata  input  NUM_CH*DATA_W  concatenated FIFO read data, channel c at [c*DATA_W +: DATA_W]
o_ren_ctrl  output  NUM_CH  one-hot (or zero) FIFO read enable
o_rdata  output  DATA_W  returned read data
o_rvalid  output  1  o_rdata/o_rch valid this cycle
o_rch  output  CH_W  channel id of o_rdata
o_busy  output  1  burst active or reads in flight
o_burst_done  output  1  one-cycle pulse at end of each burst

Behaviour:
- Reset (i_rest=0, async): state=IDLE; beat counter=0; last_grant=NUM_CH-1, so channel 0 wins first; latency pipeline cleared. o_ren_ctrl=0, o_rdata=0, o_rvalid=0, o_rch=0, o_busy=0, o_burst_done=0. Reset mid-burst drops in-flight reads; they are never reported.
- Eligible channel c: i_ren[c]=1 and i_empty[c]=0.
- IDLE: if any channel is eligible, pick the first eligible channel searching last_grant+1, last_grant+2, ... with modulo NUM_CH wrap. Register it as grant, clear beat counter, go to BURST. No read is issued in the IDLE cycle.
- BURST: o_ren_ctrl[grant] = i_ren[grant] & ~i_empty[grant] & ~i_stall, combinational from registered grant and current inputs. All other bits are 0. Each issued read increments the beat counter.
- BURST exit to IDLE at the clock edge when any of the following holds:
  - a read issues with beat counter = BURST_LEN-1
  - i_empty[grant]=1
  - i_ren[grant]=0

  On exit: last_grant=grant and o_burst_done pulses for 1 cycle, registered, in the cycle after the exit edge.
- i_stall=1 in BURST holds the state and counter and issues no reads. The stall alone never ends a burst.
- Re-arbitration always costs one IDLE cycle, so sustained throughput is BURST_LEN reads per BURST_LEN+1 cycles.
- Latency pipeline: a shift register of depth RD_LAT carries {valid, channel}.
  - A read issued in cycle N has its data sampled from i_rdata slice[ch] at cycle N+RD_LAT.
  - o_rdata/o_rch/o_rvalid are registered and presented at cycle N+RD_LAT+1.
  - Order is preserved; i_stall does not block return data.
- o_rdata and o_rch hold their last value when o_rvalid=0.
- o_busy = (state != IDLE) or any valid bit in the pipeline or o_rvalid.
- Fairness: a channel that remains eligible is granted within NUM_CH-1 bursts.
- Beat counter width is clog2(BURST_LEN)+1; it never wraps.
- With BURST_LEN=1, each burst is one read and o_burst_done pulses after every read.

Test Plan:
- Reset then single channel: NUM_CH=4, BURST_LEN=4, RD_LAT=1. Ch2 eligible with 10 entries. Expect:
  - IDLE one cycle, then o_ren_ctrl=4'b0100 for 4 cycles
  - one IDLE gap, repeated until 10 reads issued
  - o_rvalid 2 cycles after each ren with o_rch=2
  - o_burst_done pulses 3 times
- Round-robin: all 4 channels eligible continuously. Expect grant order 0,1,2,3,0, each 4 reads, and o_ren_ctrl never has more than 1 bit set.
- Empty mid-burst: ch1 has 2 entries. Expect 2 reads, exit on empty, zero reads while empty, and the next grant goes to ch2 if eligible.
- Stall: assert i_stall for 3 cycles after the 2nd read of a burst. Expect o_ren_ctrl=0 for those cycles, in-flight data still returned, then 2 more reads to finish the burst.
- Request drop and data check: with RD_LAT=3, drive i_rdata ch0=8'hA5 at ren+3. Expect o_rdata=8'hA5 with o_rvalid at ren+4. Deassert i_ren[0] mid-burst: the burst ends and o_burst_done pulses.
- Async reset mid-burst with 2 reads in flight: expect all outputs 0 immediately, no stale o_rvalid after release, and ch0 granted first.
